ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 16-bit data RAM between two requesters: port 0 (data/load-store, R/W)
//  and port 1 (instruction fetch, read-only). Sequences every access as IDLE->ACCESS->DONE and
//  drives the RAM's Address/Data_in/DW pins. RAM read is asynchronous; the arbiter registers it.
//  Sits between the CPU control unit and the RAM instance.
// PARAMETERS
//  Data_width  16   word width, matches RAM
//  RAM_depth   256  words in RAM; ADDR_W = $clog2(RAM_depth) (localparam, 8 by default)
// PORTS
//  Clk          in   1        system clock, all state on posedge
//  Rst          in   1        synchronous reset, active-high
//  P0_Req       in   1        port 0 access request (level, held until P0_Ack)
//  P0_We        in   1        port 0: 1 = write, 0 = read
//  P0_Addr      in   ADDR_W   port 0 word address
//  P0_Wdata     in   Data_width  port 0 write data
//  P0_Ack       out  1        port 0 access complete, one-cycle pulse
//  P0_Rdata     out  Data_width  read data; valid while P0_Ack=1
//  P1_Req       in   1        port 1 (fetch) read request, held until P1_Ack
//  P1_Addr      in   ADDR_W   port 1 word address
//  P1_Ack       out  1        port 1 access complete, one-cycle pulse
//  P1_Rdata     out  Data_width  read data; valid while P1_Ack=1
//  Ram_Address  out  ADDR_W   to RAM Address
//  Ram_Data_in  out  Data_width  to RAM Data_in
//  Ram_DW       out  1        to RAM DW (write enable)
//  Ram_Data_out in   Data_width  from RAM Data_out (asynchronous read)
//  Busy         out  1        1 while state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, addr_q/wdata_q/we_q/rdata_q=0, owner_q=0, last_q=1; all outputs 0.
//  - IDLE: if any Req, pick winner, latch its addr/we/wdata (P1: we=0) and owner -> ACCESS.
//    No Req: stay IDLE. Req sampled only in IDLE.
//  - ACCESS (1 cycle): Ram_Address=addr_q, Ram_Data_in=wdata_q, Ram_DW=we_q & ~Rst;
//    at the closing edge rdata_q<=Ram_Data_out (read-before-write: old word on writes),
//    RAM write commits on the same edge -> DONE.
//  - DONE (1 cycle): Px_Ack=1 for owner only; Px_Rdata=rdata_q; last_q<=owner -> IDLE.
//  - Latency: Req high at edge E0 -> Ack high in cycle E0+2; min 3 cycles per access.
//  - Requester deasserts Req after sampling Ack; Req still high in next IDLE = new access.
//  - Ram_Address/Ram_Data_in hold addr_q/wdata_q in all states; Ram_DW=0 outside ACCESS.
//  - Both Px_Rdata driven from rdata_q; meaningful only with own Ack.
//  - Address arithmetic none; addresses passed unmodified, full 0..RAM_depth-1 range.
//  - Fixed priority (default): both Req in IDLE -> port 0 wins. P1 may starve; by design.
//  - Rst in any state: next cycle IDLE, no Ack issued, in-flight write suppressed
//    (Ram_DW gated by ~Rst), RAM contents not cleared.
// CONFIGURATION
//  RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous Req the port != last_q wins
//  (last_q resets to 1, so port 0 wins first tie). Single Req always wins immediately.
//  Undefined: fixed priority port 0 > port 1; last_q still maintained but unused.
// STRUCTURE
//  Package ram_arb_pkg: state encoding (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2),
//  port ids (PORT_DATA=1'b0, PORT_FETCH=1'b1).
//  Sub-module ram_arb_pick: combinational winner select (P0_Req, P1_Req, last_q -> grant,
//  owner), holds the RAM_ARB_ROUND_ROBIN_EN ifdef. FSM + latches in ram_arbiter.
//  Bench instantiates real RAM module behind the arbiter.
// TESTING
//  1 Reset: Rst=1 two cycles with Reqs high -> all outputs 0, Busy=0, no RAM write.
//  2 P0 write Addr=0x05 Wdata=0xBEEF -> Ram_DW=1 in cycle E0+1 only, P0_Ack at E0+2;
//    then P1 read 0x05 -> P1_Ack at E0+2, P1_Rdata=0xBEEF.
//  3 Read-before-write: RAM[0x10]=0x1111, P0 write 0x2222 -> P0_Rdata=0x1111 on Ack,
//    following P0 read 0x10 -> 0x2222.
//  4 Tie, both Req same cycle: default -> P0_Ack at E0+2, P1_Ack at E0+5;
//    RAM_ARB_ROUND_ROBIN_EN after a prior P0 access -> P1 acked first.
//  5 Rst asserted during ACCESS of P0 write 0x00FF->0x3C -> Ram_DW=0, RAM[0x3C] unchanged,
//    no Ack, Busy=0 next cycle.
//  6 Edge address 0xFF write 0xA5A5 then read; P0_Req held high -> Ack every 3 cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : State encoding and port identifiers for the RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_DATA  = 1'b0;
    localparam logic PORT_FETCH = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pick
// Brief    : Combinational winner select between the data and fetch ports.
//            Define RAM_ARB_ROUND_ROBIN_EN to alternate on ties.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic i_p0_req,
    input  logic i_p1_req,
    input  logic i_last,
    output logic o_grant,
    output logic o_owner
);

    assign o_grant = i_p0_req | i_p1_req;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last wins.
    always_comb begin
        if (i_p0_req && i_p1_req) begin
            o_owner = ~i_last;
        end else if (i_p1_req) begin
            o_owner = PORT_FETCH;
        end else begin
            o_owner = PORT_DATA;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign o_owner       = i_p0_req ? PORT_DATA : (i_p1_req ? PORT_FETCH : PORT_DATA);
`endif

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares a single-port data RAM between a load/store port and an
//            instruction-fetch port (IDLE -> ACCESS -> DONE per access).
//            Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int RAM_DEPTH  = 256,
    localparam int c_ADDR_W   = $clog2(RAM_DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  P0_Req,
    input  logic                  P0_We,
    input  logic [c_ADDR_W-1:0]   P0_Addr,
    input  logic [DATA_WIDTH-1:0] P0_Wdata,
    output logic                  P0_Ack,
    output logic [DATA_WIDTH-1:0] P0_Rdata,
    input  logic                  P1_Req,
    input  logic [c_ADDR_W-1:0]   P1_Addr,
    output logic                  P1_Ack,
    output logic [DATA_WIDTH-1:0] P1_Rdata,
    output logic [c_ADDR_W-1:0]   Ram_Address,
    output logic [DATA_WIDTH-1:0] Ram_Data_in,
    output logic                  Ram_DW,
    input  logic [DATA_WIDTH-1:0] Ram_Data_out,
    output logic                  Busy
);

    state_t                r_state;
    logic [c_ADDR_W-1:0]   r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_we;
    logic                  r_owner;
    logic                  r_last;
    logic                  r_p0_ack;
    logic                  r_p1_ack;
    logic                  r_busy;
    logic                  w_grant;
    logic                  w_owner;

    ram_arb_pick u_pick (
        .i_p0_req (P0_Req),
        .i_p1_req (P1_Req),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_owner  (w_owner)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
            r_owner  <= PORT_DATA;
            r_last   <= PORT_FETCH;
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_owner;
                        if (w_owner == PORT_DATA) begin
                            r_addr  <= P0_Addr;
                            r_wdata <= P0_Wdata;
                            r_we    <= P0_We;
                        end else begin
                            r_addr  <= P1_Addr;
                            r_we    <= 1'b0;
                        end
                        r_state <= ST_ACCESS;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // Captured on the same edge the write commits, so writes return the old word.
                    r_rdata  <= Ram_Data_out;
                    r_p0_ack <= (r_owner == PORT_DATA);
                    r_p1_ack <= (r_owner == PORT_FETCH);
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_last  <= r_owner;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Ram_Address = r_addr;
    assign Ram_Data_in = r_wdata;
    assign Ram_DW      = r_we & (r_state == ST_ACCESS) & ~Rst;
    assign P0_Ack      = r_p0_ack;
    assign P1_Ack      = r_p1_ack;
    assign P0_Rdata    = r_rdata;
    assign P1_Rdata    = r_rdata;
    assign Busy        = r_busy;

endmodule
`default_nettype wire
